// File: rtl/decim_accum_pkg.sv
// -----------------------------------------------------------------------------
// decim_accum_pkg
// Definitions shared by the filter, the decimating accumulator and their
// benches: default sample width, error-counter width, a ceil(log2) helper
// usable in parameter expressions, and the even-parity (XOR-reduce) function.
// -----------------------------------------------------------------------------
package decim_accum_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ERR_CNT_W  = 8;

    // ceil(log2(n)); returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Even parity of up to 64 bits; narrower callers zero-extend, which does
    // not change the XOR result.
    function automatic logic parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Show-ahead synchronous FIFO. dout always presents the head entry (zero when
// empty). A push while full is accepted only if a pop happens in the same
// cycle; otherwise it is ignored and the caller decides how to report it.
// Ports: clk, rst (sync, active-high), push/din, pop, full, empty, dout.
// -----------------------------------------------------------------------------
module sync_fifo
    import decim_accum_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // When full, the slot being freed by a same-cycle pop is the one written.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/decim_accum.sv
// -----------------------------------------------------------------------------
// decim_accum
// Sits after the 16-bit filter. Registers the free-running sample stream,
// checks its parity, sums DECIM good samples into one result and queues the
// results in a show-ahead FIFO offered over valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   x_data/x_valid/x_parity   filter stream (no backpressure)
//   y_data/y_valid/y_ready    decimated result handshake (FIFO head)
//   y_parity            XOR reduction of y_data
//   err_count           saturating count of parity-failed samples
//   overflow            sticky: a result was dropped on a full FIFO
// -----------------------------------------------------------------------------
module decim_accum
    import decim_accum_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int DECIM      = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int ACC_W      = DATA_W + clog2(DECIM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    x_data,
    input  logic                 x_valid,
    input  logic                 x_parity,
    output logic [ACC_W-1:0]     y_data,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic                 y_parity,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 overflow
);

    localparam int CNT_W = clog2(DECIM);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] x_data_p0;
    logic              vld_p0;
    logic              perr_p0;
    logic [ACC_W-1:0]  acc_p1;
    logic [CNT_W-1:0]  cnt_p1;

    logic              good_p0;
    logic              last_p0;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ACC_W-1:0]  sum_p0;

    // ---- stage 0: input register and parity check ----
    always_ff @(posedge clk) begin
        if (rst) begin
            x_data_p0 <= '0;
            vld_p0    <= 1'b0;
            perr_p0   <= 1'b0;
        end else begin
            x_data_p0 <= x_data;
            vld_p0    <= x_valid;
            perr_p0   <= x_valid & (parity(64'(x_data)) != x_parity);
        end
    end

    assign good_p0 = vld_p0 & ~perr_p0;
    assign last_p0 = (cnt_p1 == CNT_W'(DECIM - 1));
    assign sum_p0  = acc_p1 + ACC_W'(x_data_p0);
    assign push    = good_p0 & last_p0;
    assign pop     = y_valid & y_ready;

    // ---- stage 1: accumulate, count, push completed sums ----
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p1 <= '0;
            cnt_p1 <= '0;
        end else if (good_p0) begin
            if (last_p0) begin
                acc_p1 <= '0;
                cnt_p1 <= '0;
            end else begin
                acc_p1 <= sum_p0;
                cnt_p1 <= cnt_p1 + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (vld_p0 & perr_p0)     err_count <= sat_inc(err_count);
            if (push & full & ~pop)   overflow  <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sum_p0),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .dout  (y_data)
    );

    assign y_valid  = ~empty;
    assign y_parity = parity(64'(y_data));

endmodule

// File: tb/tb_decim_accum.sv
// -----------------------------------------------------------------------------
// tb_decim_accum
// Self-checking bench for decim_accum: a table of sample records with their
// expected decimated sums, plus hand-written sequences for latency, overflow,
// reset mid-accumulation and push/pop on a full FIFO. Expected sums go into a
// scoreboard queue when the completing sample is driven and are compared
// whenever the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_decim_accum;

    localparam int ACC_W = 18;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      x_data;
    logic             x_valid;
    logic             x_parity;
    logic [ACC_W-1:0] y_data;
    logic             y_valid;
    logic             y_ready;
    logic             y_parity;
    logic [7:0]       err_count;
    logic             overflow;

    always #5 clk = ~clk;

    decim_accum dut (
        .clk       (clk),
        .rst       (rst),
        .x_data    (x_data),
        .x_valid   (x_valid),
        .x_parity  (x_parity),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_parity  (y_parity),
        .err_count (err_count),
        .overflow  (overflow)
    );

    typedef struct {
        logic [15:0]      d;
        logic             good;
        logic             push;
        logic [ACC_W-1:0] sum;
    } vec_t;

    vec_t             tbl [14];
    logic [ACC_W-1:0] exp_q [$];
    int               checks = 0;
    int               errors = 0;
    logic             stall_prev = 1'b0;
    logic [ACC_W-1:0] stall_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: monitor outputs on the falling edge, return 1 time unit
    // after the rising edge so the caller can drive the next inputs.
    task automatic step();
        logic [ACC_W-1:0] e;
        @(negedge clk);
        if (!rst && stall_prev)
            chk("stall_hold", {13'd0, y_valid, y_data}, {13'd0, 1'b1, stall_data});
        if (!rst && y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got y_data %0h, expected no output", y_data);
            end else begin
                e = exp_q.pop_front();
                chk("y_data", 32'(y_data), 32'(e));
                chk("y_parity", 32'(y_parity), 32'(^e));
            end
        end
        stall_prev = !rst && y_valid && !y_ready;
        stall_data = y_data;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic good);
        x_data   = d;
        x_valid  = 1'b1;
        x_parity = good ? ^d : ~(^d);
        step();
        x_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        x_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_group(input logic [15:0] v, input logic expect_out);
        for (int i = 0; i < 4; i++) send(v, 1'b1);
        if (expect_out) exp_q.push_back(ACC_W'(v) * 4);
    endtask

    task automatic drain(input string name);
        y_ready = 1'b1;
        x_valid = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d results outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        step();
        chk({name, "_empty"}, 32'(y_valid), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        x_data   = '0;
        x_valid  = 1'b0;
        x_parity = 1'b0;
        y_ready  = 1'b1;

        tbl[0]  = '{16'h0001, 1'b1, 1'b0, 18'h0};
        tbl[1]  = '{16'h0001, 1'b1, 1'b0, 18'h0};
        tbl[2]  = '{16'h0001, 1'b0, 1'b0, 18'h0};
        tbl[3]  = '{16'h0001, 1'b1, 1'b0, 18'h0};
        tbl[4]  = '{16'h0001, 1'b1, 1'b1, 18'h00004};
        tbl[5]  = '{16'hFFFF, 1'b1, 1'b0, 18'h0};
        tbl[6]  = '{16'hFFFF, 1'b1, 1'b0, 18'h0};
        tbl[7]  = '{16'hFFFF, 1'b1, 1'b0, 18'h0};
        tbl[8]  = '{16'hFFFF, 1'b1, 1'b1, 18'h3FFFC};
        tbl[9]  = '{16'h0005, 1'b1, 1'b0, 18'h0};
        tbl[10] = '{16'h0100, 1'b1, 1'b0, 18'h0};
        tbl[11] = '{16'h0007, 1'b0, 1'b0, 18'h0};
        tbl[12] = '{16'h0000, 1'b1, 1'b0, 18'h0};
        tbl[13] = '{16'h8000, 1'b1, 1'b1, 18'h08105};

        // Reset state
        step();
        step();
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_data", 32'(y_data), 32'd0);
        chk("rst_y_parity", 32'(y_parity), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Basic sum of four 3s and its latency
        for (int i = 0; i < 3; i++) send(16'd3, 1'b1);
        send(16'd3, 1'b1);
        exp_q.push_back(18'h0000C);
        chk("t1_no_bypass", 32'(y_valid), 32'd0);
        idle(1);
        chk("t1_y_valid", 32'(y_valid), 32'd1);
        chk("t1_y_data", 32'(y_data), 32'h0000C);
        idle(1);
        chk("t1_y_valid_drop", 32'(y_valid), 32'd0);

        // Table: parity errors excluded, full-scale sum, mixed values
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].d, tbl[i].good);
            if (tbl[i].push) exp_q.push_back(tbl[i].sum);
            if (i == 4) chk("t2_err_count", 32'(err_count), 32'd1);
        end
        drain("table");
        chk("table_err_count", 32'(err_count), 32'd2);

        // Overflow: five groups with the consumer stalled, fifth is lost
        y_ready = 1'b0;
        for (int g = 1; g <= 4; g++) send_group(16'(g), 1'b1);
        idle(2);
        chk("t4_full_no_ovf", 32'(overflow), 32'd0);
        send_group(16'd5, 1'b0);
        idle(2);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_head", 32'(y_data), 32'd4);
        drain("t4");
        chk("t4_overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-accumulation discards the partial sum
        send(16'd7, 1'b1);
        send(16'd7, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t5_err_cleared", 32'(err_count), 32'd0);
        chk("t5_ovf_cleared", 32'(overflow), 32'd0);
        send_group(16'd1, 1'b1);
        drain("t5");

        // Full FIFO: push and pop on the same edge
        y_ready = 1'b0;
        for (int g = 10; g <= 13; g++) send_group(16'(g), 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) send(16'd14, 1'b1);
        send(16'd14, 1'b1);
        exp_q.push_back(18'd56);
        y_ready = 1'b1;
        idle(1);
        y_ready = 1'b0;
        idle(1);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_head", 32'(y_data), 32'd44);
        chk("t6_outstanding", 32'(exp_q.size()), 32'd4);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decim_accum.md
Name: decim_accum

Overview:
Stage directly downstream of the 16-bit filter block. Consumes the filter's free-running data/valid/parity stream and checks parity on every valid sample. Sums DECIM good samples into one decimated result and buffers results in a small FIFO. Results are offered to the next consumer over a valid/ready handshake. The filter has no backpressure, so this block absorbs rate mismatch and reports overflow.

Parameters:
DATA_W, 16, input sample width
DECIM, 4, good samples summed per output (>=2)
FIFO_DEPTH, 4, result FIFO entries (power of 2)
ACC_W (localparam), DATA_W+clog2(DECIM), accumulator/output width; 18 at defaults

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
x_data  in  DATA_W  sample from filter
x_valid  in  1  sample qualifier; no ready returned upstream
x_parity  in  1  even parity of x_data (XOR reduction of all bits)
y_data  out  ACC_W  FIFO head: decimated sum
y_valid  out  1  FIFO non-empty
y_ready  in  1  consumer accepts head when y_valid&y_ready
y_parity  out  1  XOR reduction of y_data, combinational from head
err_count  out  8  parity errors seen, saturates at 255
overflow  out  1  sticky: result dropped because FIFO full

Behaviour:
- Reset (sync, rst=1 at edge) clears the following:
  - input register, accumulator, sample counter, FIFO pointers/count
  - err_count=0, overflow=0
  - outputs: y_valid=0, y_data=0, y_parity=0
  - Takes priority over all activity, including mid-accumulation and mid-handshake. The partial sum is discarded.
- Stage 1 (edge k): register x_data, x_valid, and perr = (^x_data != x_parity) & x_valid.
- Stage 2 (edge k+1), acting on the registered sample:
  - invalid: no change.
  - perr: sample discarded. Does not advance the counter or add to the accumulator. err_count+1, saturating at 255.
  - good, cnt<DECIM-1: acc+=sample, cnt+=1.
  - good, cnt==DECIM-1: push acc+sample to FIFO, then acc=0, cnt=0.
- Latency: the DECIM-th good sample presented at edge k shows y_valid=1 after edge k+1. There is no bypass path.
- Arithmetic: unsigned zero-extension to ACC_W. The sum cannot overflow by construction.
- FIFO: show-ahead, so y_data is always the head entry.
  - Pop on y_valid&y_ready.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push while full without pop: result dropped, overflow set (sticky until rst), contents unchanged.
  - Push into empty with y_ready=1: entry appears next cycle; no same-cycle pop.
- Handshake: y_data and y_valid stay stable while y_valid&!y_ready.
- Counter: cnt is clog2(DECIM) bits and wraps to 0 only on push.

Decomposition:
- Shared package (shared with the filter and its testbenches):
  - DATA_W default
  - parity function (XOR reduce)
  - clog2 helper
  - err_count width constant
- One sub-module, sync_fifo:
  - parameters WIDTH, DEPTH
  - ports: push/pop, full/empty, show-ahead dout
  - owns the pointer wrap and simultaneous push/pop rules
- decim_accum owns the input register, parity check, accumulator/counter, error counter and overflow flag.

Test Plan:
1. rst 2 cycles, then x_data=3, x_parity=0, x_valid=1 for 4 cycles, y_ready=1 -> y_valid=1 with y_data=0x0000C and y_parity=0, two edges after the 4th sample; y_valid drops the cycle after acceptance.
2. Stream 1,1 (good), 1 with x_parity=0 (bad), then 1,1 good -> err_count=1; single output y_data=4 (bad sample excluded).
3. x_data=0xFFFF, x_parity=0 for 4 samples -> y_data=0x3FFFC, y_parity=0; no truncation.
4. y_ready=0, 5 groups of 4 samples, group g = value g (g=1..5) -> overflow=1; then y_ready=1 drains 4,8,12,16 in order; 20 is lost; y_valid=0 afterward.
5. Feed 2 good samples of 7, assert rst 1 cycle, then 4 samples of 1 -> y_data=4 (partial 14 discarded); err_count=0, overflow=0 after rst.
6. FIFO full, y_ready=1, and a push in the same cycle -> one pop plus one push; count stays 4; overflow stays 0; order preserved.
